instr_seq_ctrl: RTL

- Multi-cycle sequencer for the single-issue RV32I core.
- Fetches each instruction over a req/ack handshake, latches its opcode and classifies it.
- Drives the one-hot type enables (R/I/S/SB/U/UJ) into the decode unit.
- Steps the datapath through FETCH→DECODE→EXECUTE→[MEM]→[WB] and traps on illegal opcodes or handshake timeouts.

---
 rtl/instr_seq_ctrl_if.sv | 20 ++
 rtl/instr_seq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_seq_ctrl_if.sv
// Fetch and data-memory handshake bundle between the sequencer (master) and the
// instruction/data memories (slave).
interface instr_seq_ctrl_if;
  logic [31:0] instr_i;
  logic        instr_ack_i;
  logic        instr_req_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        mem_ack_i;

  modport master (
    input  instr_i, instr_ack_i, mem_ack_i,
    output instr_req_o, mem_req_o, mem_we_o
  );

  modport slave (
    output instr_i, instr_ack_i, mem_ack_i,
    input  instr_req_o, mem_req_o, mem_we_o
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle RV32I instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB with traps.
// Optional retired-instruction counter enabled by defining INSTR_SEQ_INSTRET_EN.
module instr_seq_ctrl #(
  parameter int TIMEOUT_CYCLES    = 16,
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     trap_clr_i,
  instr_seq_ctrl_if.master         bus,
  output logic                     R_EN_o,
  output logic                     I_EN_o,
  output logic                     S_EN_o,
  output logic                     SB_EN_o,
  output logic                     U_EN_o,
  output logic                     UJ_EN_o,
  output logic                     rf_we_o,
  output logic                     pc_en_o,
  output logic [2:0]               state_o,
  output logic                     trap_o,
  output logic [1:0]               trap_cause_o,
  output logic [31:0]              instret_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    TRAP    = 3'd6
  } state_t;

  localparam state_t RST_STATE = RESET_STATE_FETCH ? FETCH : IDLE;
  localparam int     CW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t          state_reg, state_next;
  logic [6:0]      opcode_reg, opcode_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      cause_reg, cause_next;

  logic [5:0]      type_en;
  logic            is_load, is_store, is_branch, legal, timeout_hit, en_active;
  logic            ireq_c, mreq_c, mwe_c, rfwe_c, pcen_c, trap_c;
  logic            instr_unused;

  assign instr_unused = ^bus.instr_i[31:7];

  // Type bits ordered {R, I, S, SB, U, UJ}.
  always_comb begin
    type_en   = 6'b000000;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    case (opcode_reg)
      7'b0110011: type_en = 6'b100000;
      7'b0010011: type_en = 6'b010000;
      7'b0000011: begin type_en = 6'b010000; is_load = 1'b1; end
      7'b1100111: type_en = 6'b010000;
      7'b0100011: begin type_en = 6'b001000; is_store = 1'b1; end
      7'b1100011: begin type_en = 6'b000100; is_branch = 1'b1; end
      7'b0110111: type_en = 6'b000010;
      7'b0010111: type_en = 6'b000010;
      7'b1101111: type_en = 6'b000001;
      default:    type_en = 6'b000000;
    endcase
  end

  assign legal       = |type_en;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= RST_STATE;
      opcode_reg <= 7'd0;
      cnt_reg    <= '0;
      cause_reg  <= 2'd0;
    end else begin
      state_reg  <= state_next;
      opcode_reg <= opcode_next;
      cnt_reg    <= cnt_next;
      cause_reg  <= cause_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    opcode_next = opcode_reg;
    cause_next  = cause_reg;
    cnt_next    = '0;
    ireq_c      = 1'b0;
    mreq_c      = 1'b0;
    mwe_c       = 1'b0;
    rfwe_c      = 1'b0;
    pcen_c      = 1'b0;
    trap_c      = 1'b0;
    case (state_reg)
      IDLE: if (start_i) state_next = FETCH;
      FETCH: begin
        ireq_c = 1'b1;
        if (bus.instr_ack_i) begin
          opcode_next = bus.instr_i[6:0];
          state_next  = DECODE;
        end else if (timeout_hit) begin
          state_next = TRAP;
          cause_next = 2'd2;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DECODE: begin
        if (legal) begin
          state_next = EXECUTE;
        end else begin
          state_next = TRAP;
          cause_next = 2'd1;
        end
      end
      EXECUTE: begin
        if (is_load || is_store) begin
          state_next = MEM;
        end else if (is_branch) begin
          pcen_c     = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        mreq_c = 1'b1;
        mwe_c  = is_store;
        if (bus.mem_ack_i) begin
          // A store retires on its ack; a load still needs its write-back cycle.
          pcen_c     = is_store;
          state_next = is_store ? FETCH : WB;
        end else if (timeout_hit) begin
          state_next = TRAP;
          cause_next = 2'd3;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      WB: begin
        rfwe_c     = 1'b1;
        pcen_c     = 1'b1;
        state_next = FETCH;
      end
      TRAP: begin
        trap_c = 1'b1;
        if (trap_clr_i) begin
          state_next = FETCH;
          cause_next = 2'd0;
        end
      end
      default: state_next = RST_STATE;
    endcase
  end

  assign en_active = (state_reg == DECODE) || (state_reg == EXECUTE) ||
                     (state_reg == MEM)    || (state_reg == WB);

  // Outputs are forced low while reset is held so a request in flight drops at once.
  assign bus.instr_req_o = ireq_c & ~rst_i;
  assign bus.mem_req_o   = mreq_c & ~rst_i;
  assign bus.mem_we_o    = mwe_c  & ~rst_i;
  assign rf_we_o         = rfwe_c & ~rst_i;
  assign pc_en_o         = pcen_c & ~rst_i;
  assign trap_o          = trap_c & ~rst_i;
  assign trap_cause_o    = rst_i ? 2'd0 : cause_reg;
  assign state_o         = rst_i ? 3'd0 : state_reg;
  assign R_EN_o          = en_active & type_en[5] & ~rst_i;
  assign I_EN_o          = en_active & type_en[4] & ~rst_i;
  assign S_EN_o          = en_active & type_en[3] & ~rst_i;
  assign SB_EN_o         = en_active & type_en[2] & ~rst_i;
  assign U_EN_o          = en_active & type_en[1] & ~rst_i;
  assign UJ_EN_o         = en_active & type_en[0] & ~rst_i;

`ifdef INSTR_SEQ_INSTRET_EN
  logic [31:0] instret_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instret_reg <= 32'd0;
    end else if (pcen_c) begin
      instret_reg <= instret_reg + 32'd1;
    end
  end

  assign instret_o = instret_reg;
`else
  assign instret_o = 32'd0;
`endif

endmodule
